// File: rtl/hdb3_pkg.sv
// hdb3_pkg: symbol types, pipeline latency and output polarity codes for the HDB3 encoder.
package hdb3_pkg;
   typedef enum logic [1:0] {ZERO, ONE, B, V} sym_t;
   localparam int LATENCY = 4;
   localparam logic [1:0] OUT_ZERO = 2'b00;
   localparam logic [1:0] OUT_POS  = 2'b10;
   localparam logic [1:0] OUT_NEG  = 2'b01;
endpackage

// File: rtl/hdb3_polarity.sv
// hdb3_polarity: assigns AMI/violation polarity to each leaving symbol and registers o_p/o_n.
// Optional V flag output when HDB3_VFLAG_EN is defined.
module hdb3_polarity
   import hdb3_pkg::*;
#(
   parameter logic INIT_POL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  sym_t sym,
   output logic p,
   output logic n
`ifdef HDB3_VFLAG_EN
   ,
   output logic v
`endif
);
   logic last, pol, pulse;
   assign pulse = sym != ZERO;
   // violations repeat the previous pulse polarity, marks and B pulses alternate
   assign pol = (sym == V) ? last : ~last;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {p, n} <= OUT_ZERO;
         last   <= INIT_POL;
`ifdef HDB3_VFLAG_EN
         v      <= 1'b0;
`endif
      end else begin
         {p, n} <= !pulse ? OUT_ZERO : (pol ? OUT_POS : OUT_NEG);
         if (pulse) last <= pol;
`ifdef HDB3_VFLAG_EN
         v      <= sym == V;
`endif
      end
   end
endmodule

// File: rtl/hdb3_encoder.sv
// hdb3_encoder: NRZ to HDB3 encoder, 4-clock latency, B00V/000V substitution in a symbol pipeline.
// Define HDB3_VFLAG_EN to add the o_v violation flag output.
module hdb3_encoder
   import hdb3_pkg::*;
#(
   parameter logic INIT_POL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_data,
   output logic o_p,
   output logic o_n
`ifdef HDB3_VFLAG_EN
   ,
   output logic o_v
`endif
);
   sym_t pipe [LATENCY];
   logic [1:0] zrun;
   logic parity, fourth;
   assign fourth = !i_data && zrun == 2'd3;
   // the first zero of the run sits in the last stage-to-be, so B replaces it on the way out
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= ZERO;
         zrun   <= 2'd0;
         parity <= 1'b0;
      end else begin
         pipe[0] <= fourth ? V : (i_data ? ONE : ZERO);
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
         pipe[3] <= (fourth && !parity) ? B : pipe[2];
         zrun    <= (i_data || fourth) ? 2'd0 : zrun + 2'd1;
         parity  <= fourth ? 1'b0 : parity ^ i_data;
      end
   end
   hdb3_polarity #(.INIT_POL(INIT_POL)) u_pol (
      .clk   (i_clk),
      .rst_n (i_rst),
      .sym   (pipe[LATENCY-1]),
      .p     (o_p),
      .n     (o_n)
`ifdef HDB3_VFLAG_EN
      ,
      .v     (o_v)
`endif
   );
endmodule

// File: tb/tb_hdb3_encoder.sv
// tb_hdb3_encoder: directed checks of hdb3_encoder against hand-computed sequences and a bit-level HDB3 model.
module tb_hdb3_encoder;
   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] N = 2'b01;
   localparam logic [1:0] Z = 2'b00;
   localparam int LEN = 130;
   logic i_clk = 1'b0, i_rst = 1'b0, i_data = 1'b0;
   logic o_p, o_n;
`ifdef HDB3_VFLAG_EN
   logic o_v;
`endif
   int passed = 0, total = 0;
   logic [64:0] pat = 65'b11000010000000011000011100001111001010001100000000000011100001101;
   bit pb [LEN];
   bit isv [LEN];
   logic [1:0] ex [LEN];
   logic [1:0] got [LEN];
   logic [1:0] last_nv, last_v;
   bit lastp, par, have_nv, have_v;
   int zr, idx;

   hdb3_encoder dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (i_data),
      .o_p    (o_p),
      .o_n    (o_n)
`ifdef HDB3_VFLAG_EN
      ,
      .o_v    (o_v)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic step(input logic d);
      i_data = d;
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      #3;
      i_rst = 1'b1;
   endtask

   // feeds n bits (MSB first) plus 4 flush zeros; output j is checked 4 edges after input j
   task automatic run(input string tag, input int n, input logic [8:0] bits, input logic [17:0] exp,
                      input logic [8:0] vm);
      for (int s = 0; s < n + 4; s++) begin
         step(s < n ? bits[n-1-s] : 1'b0);
         if (s >= 4) begin
            check(tag, {o_p, o_n}, exp[2*(n+3-s)+:2]);
`ifdef HDB3_VFLAG_EN
            check({tag, "_v"}, {1'b0, o_v}, {1'b0, vm[n+3-s]});
`else
            if (vm[n+3-s]) check({tag, "_pulse_at_v"}, {1'b0, o_p | o_n}, 2'b01);
`endif
         end
      end
   endtask

   initial begin
      #2;
      check("reset_out", {o_p, o_n}, Z);
`ifdef HDB3_VFLAG_EN
      check("reset_v", {1'b0, o_v}, 2'b00);
`endif
      i_rst = 1'b1;
      run("b00v", 7, 9'b001100001, {Z, Z, P, N, P, Z, Z, P, N}, 9'b000000010);
      do_reset();
      run("000v", 6, 9'b000100001, {Z, Z, Z, P, Z, Z, Z, P, N}, 9'b000000010);
      do_reset();
      run("alt_v", 9, 9'b100000000, {P, Z, Z, Z, P, N, Z, Z, N}, 9'b000010001);
      do_reset();
      step(1'b1);
      for (int s = 0; s < 4; s++) step(1'b0);
      check("pre_rst_p", {o_p, o_n}, P);
      #2;
      i_rst = 1'b0;
      #1;
      check("async_rst", {o_p, o_n}, Z);
      #3;
      i_rst = 1'b1;
      run("after_rst", 7, 9'b001100001, {Z, Z, P, N, P, Z, Z, P, N}, 9'b000000010);
      for (int i = 0; i < LEN; i++) pb[i] = pat[64 - (i % 65)];
      lastp = 1'b0;
      par = 1'b0;
      idx = 0;
      while (idx < LEN) begin
         if (pb[idx]) begin
            lastp = ~lastp;
            ex[idx] = lastp ? P : N;
            isv[idx] = 1'b0;
            par = ~par;
            idx++;
         end else if (idx + 3 < LEN && !pb[idx+1] && !pb[idx+2] && !pb[idx+3]) begin
            if (!par) lastp = ~lastp;
            ex[idx] = par ? Z : (lastp ? P : N);
            ex[idx+1] = Z;
            ex[idx+2] = Z;
            ex[idx+3] = lastp ? P : N;
            isv[idx] = 1'b0;
            isv[idx+1] = 1'b0;
            isv[idx+2] = 1'b0;
            isv[idx+3] = 1'b1;
            par = 1'b0;
            idx += 4;
         end else begin
            ex[idx] = Z;
            isv[idx] = 1'b0;
            idx++;
         end
      end
      do_reset();
      for (int s = 0; s < LEN + 4; s++) begin
         step(s < LEN ? pb[s] : 1'b0);
         if (s >= 4) got[s-4] = {o_p, o_n};
      end
      zr = 0;
      have_nv = 1'b0;
      have_v = 1'b0;
      last_nv = Z;
      last_v = Z;
      for (int i = 0; i < LEN; i++) begin
         check("model", got[i], ex[i]);
         check("both_high", {1'b0, got[i] == 2'b11}, 2'b00);
         zr = (got[i] == Z) ? zr + 1 : 0;
         check("zero_run", {1'b0, zr > 3}, 2'b00);
         if (got[i] != Z && isv[i]) begin
            if (have_v) check("v_alt", got[i], ~last_v);
            last_v = got[i];
            have_v = 1'b1;
         end else if (got[i] != Z) begin
            if (have_nv) check("mark_alt", got[i], ~last_nv);
            last_nv = got[i];
            have_nv = 1'b1;
         end
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/hdb3_encoder.md
HDB3_ENCODER -- requirements
Module: hdb3_encoder

Interface
REQ-001 The block SHALL have one parameter: INIT_POL, default 0, polarity of the last pulse after reset (0 = negative, so the first mark is sent positive; 1 = positive).
REQ-002 The port list SHALL be:
- i_clk   input  1  single clock; all state changes on the rising edge.
- i_rst   input  1  asynchronous, active-low reset.
- i_data  input  1  NRZ data, one bit sampled per clock.
- o_p     output 1  registered; 1 = positive pulse.
- o_n     output 1  registered; 1 = negative pulse.

Function
REQ-003 Output symbol coding SHALL be: o_p=1,o_n=0 positive; o_p=0,o_n=1 negative; both 0 zero; both 1 SHALL never occur.
REQ-004 The block SHALL sample i_data every clock into a 4-stage symbol pipeline with symbol types ZERO, ONE, B, V.
REQ-005 Input bit sampled at edge k SHALL appear on o_p/o_n after edge k+4, so latency is 4 clocks with no bubbles.
REQ-006 A zero-run counter SHALL count consecutive input zeros, clear on an input 1, and saturate at no value.
REQ-007 When the 4th consecutive zero is sampled, that zero SHALL become V and the counter SHALL clear.
REQ-008 At the same edge as REQ-007, if pulse parity is even, the 1st zero of the run (3 stages ahead) SHALL become B, giving B00V; if parity is odd, the run SHALL be sent as 000V.
REQ-009 Pulse parity SHALL toggle on each ONE or B entering the pipeline and SHALL clear to even on each V.
REQ-010 Each ONE and each B SHALL take the polarity opposite to the last pulse sent.
REQ-011 Each V SHALL take the same polarity as the last pulse sent, which guarantees consecutive Vs alternate.
REQ-012 The last-pulse polarity register SHALL update on every ONE, B and V leaving the pipeline.
REQ-013 The encoded output SHALL never contain more than 3 consecutive zero symbols once the pipeline is full.

Reset
REQ-014 While i_rst=0, o_p and o_n SHALL be 0 immediately, without waiting for a clock.
REQ-015 Reset SHALL clear the pipeline to ZERO, the zero-run counter to 0 and parity to even, and SHALL set the last-pulse polarity to INIT_POL.
REQ-016 Pipeline fill zeros after reset SHALL NOT count toward the zero-run counter.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight symbols; encoding after release SHALL match encoding from power-up.

Configuration
REQ-018 With macro HDB3_VFLAG_EN defined, the block SHALL add output o_v (1 bit, registered, reset 0) that is 1 exactly in the cycles where o_p/o_n carry a V symbol.
REQ-019 Without HDB3_VFLAG_EN, o_v SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 Package hdb3_pkg SHALL hold the symbol type enum (ZERO, ONE, B, V), the constant LATENCY=4, and the output polarity encodings.
REQ-021 Polarity assignment (REQ-010 to REQ-012 plus the output register) SHALL live in one sub-module, hdb3_polarity.
REQ-022 Zero-run detection, B/V substitution and parity SHALL live in the top level.

Verification
REQ-023 Assert i_rst=0 mid-stream with o_p=1 -> o_p=o_n=0 within the same time step, with no clock edge needed.
REQ-024 After reset (INIT_POL=0), input 1,1,0,0,0,0,1 -> from the 4th clock on, outputs are P,N,P,0,0,P,N (B00V with B=+ and V=+).
REQ-025 After reset, input 1,0,0,0,0,1 -> outputs are P,0,0,0,P,N (odd parity gives 000V; V repeats +).
REQ-026 After reset, input 1 followed by 8 zeros -> outputs are P,0,0,0,P,N,0,0,N (000V then B00V; the Vs alternate).
REQ-027 For the 65-bit pattern 11000010000000011000011100001111001010001100000000000011100001101 sent twice back-to-back, checks SHALL pass against a reference model:
- o_p and o_n are never both 1;
- there are never more than 3 zeros in a row;
- every non-V pulse alternates polarity;
- successive Vs alternate polarity.
REQ-028 With HDB3_VFLAG_EN defined, under the REQ-026 stimulus, o_v SHALL be 1 exactly in output cycles 5 and 9.
